wb_dma_copy: RTL and testbench
==============================

# wb_dma_copy

Wishbone B3 bus master that copies a block of 32-bit words from one address range to another. It is the initiator counterpart of the memory and ROM slaves on the system interconnect, and attaches as an additional master port beside the CPU instruction/data and debug masters. Each transfer reads a chunk into an internal buffer, then writes that chunk out, repeating until the requested length is done. The block is controlled by a start pulse on plain ports, not through a slave register interface.

## Interface
- BUF_DEPTH, 8: words per chunk; power of two, minimum 2.
- LEN_W, 16: width of the length port, in words.
- wb_clk_i  in  1  system clock. One clock domain.
- wb_rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  starts a transfer. Sampled only while idle.
- src_adr_i  in  32  source byte address. Bits [1:0] are ignored.
- dst_adr_i  in  32  destination byte address. Bits [1:0] are ignored.
- len_i  in  LEN_W  number of words to copy.
- busy_o  out  1  high while a transfer is in progress.
- done_o  out  1  one-cycle pulse when a transfer ends (normal end or abort).
- err_o  out  1  sticky abort flag; cleared on the next accepted start.
- wbm_adr_o  out  32  bus address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte selects; always 4'hF during a cycle.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_cti_o  out  3  cycle type identifier.
- wbm_bte_o  out  2  burst type; always 2'b00 (linear).
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  bus error.
- wbm_rty_i  in  1  retry.

## Operation
- FSM states: IDLE, READ, GAP, WRITE.
- **IDLE, start_i=1, len_i≠0:**
  - Latch src, dst and remaining=len_i; clear err_o.
  - chunk = min(remaining, BUF_DEPTH); idx = 0.
  - Go to READ.
- **IDLE, start_i=1, len_i=0:** pulse done_o on the next cycle; no bus activity.
- **READ:**
  - Drive we=0 and adr={src[31:2],2'b00}.
  - On ack: store wbm_dat_i into buf[idx], advance src by 4, increment idx.
  - After the ack of beat chunk-1: go to GAP (next phase WRITE), idx reset to 0.
- **WRITE:**
  - Drive we=1 and dat=buf[idx] to dst; advance as in READ.
  - After the last ack: remaining -= chunk.
  - If remaining=0: go to IDLE and pulse done_o. Otherwise go to GAP (next phase READ).
- **GAP:** cyc_o and stb_o low for exactly one cycle between phases.
- **Retry:** rty_i is treated as no ack. stb stays high and the same beat (same address and data) is retried.
- **Error:** err_i in READ or WRITE aborts the transfer.
  - cyc_o and stb_o go low on the next edge; err_o is set; done_o pulses; state returns to IDLE.
  - A chunk that was partially read is never written.
- **Ignored inputs:** start_i while busy is ignored. An ack while stb_o is low is ignored.
- **Address arithmetic:** 32-bit, wraps modulo 2^32 with no error. remaining is LEN_W bits wide.
- **Buffer:** contents are not reset.

## Timing
- **Reset values:** all outputs 0, state IDLE.
- **Reset mid-transfer:** cyc_o and stb_o are 0 after the edge; no done_o pulse.
- **Start latency:** all outputs are registered. Start accepted in cycle n → cyc_o, stb_o and busy_o high in cycle n+1.
- **Burst throughput:** one beat per cycle with continuous ack. The address updates in the cycle after each ack.
- **cti:** with bursts enabled, 3'b010 on every beat except the last beat of a chunk, which carries 3'b111.
- **End of transfer:** done_o is high in the cycle after the final ack; busy_o falls in that same cycle.
- **Abort:** done_o pulses in the cycle after err_i is seen.
- **Ordering:** a new start can be accepted in the cycle after done_o.

## Configuration
- **WB_DMA_BURST_EN defined:** incrementing bursts, using the cti encoding given in Timing.
- **WB_DMA_BURST_EN undefined:**
  - Classic cycles only; cti_o is always 3'b000.
  - After each ack, cyc_o and stb_o drop for one cycle before the next beat.
  - Peak rate is one word per 2 cycles.
  - All other behaviour is identical.

## Structure
- **Shared package / include wb_dma_pkg:**
  - State encoding.
  - CTI_CLASSIC = 3'b000, CTI_INC = 3'b010, CTI_EOB = 3'b111, BTE_LINEAR = 2'b00.
- **Sub-module wb_dma_buf:** a BUF_DEPTH×32 register file with one synchronous write port and one combinational read port, indexed by idx.
- **Top-level contents:** the FSM, counters and address registers stay in the top-level module.

## Test plan
- **Single chunk:** len=3, src=0x100, dst=0x200, memory 0x100..0x108 = 0xA,0xB,0xC → reads at 0x100/104/108 with cti 010,010,111, then writes of 0xA/0xB/0xC to 0x200/204/208. One done_o pulse, err_o=0.
- **Two chunks:** len=10, BUF_DEPTH=8 → chunks of 8 then 2, cyc_o low exactly one cycle between each phase. 0x200..0x224 equals the source data.
- **Zero length:** len=0 → done_o in cycle n+1, busy_o stays 0, cyc_o never asserts.
- **Error abort:** err_i on the second read beat → cyc_o=0 next cycle, err_o=1, done_o pulse, no write cycle issued. A following start clears err_o.
- **Retry:** rty_i on the first write beat, then ack → the same address and data are presented again; final memory is correct.
- **Reset mid-transfer:** reset during WRITE → all outputs 0 on the next cycle and no done_o pulse. A subsequent len=2 transfer completes correctly.

Source files
------------

// File: rtl/wb_dma_pkg.sv
// wb_dma_pkg: shared constants for the Wishbone block-copy master.
package wb_dma_pkg;

  // FSM state encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;
  localparam logic [1:0] StWrite = 2'd3;

  // Wishbone B3 cycle type / burst type encodings
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_dma_buf.sv
// wb_dma_buf: BUF_DEPTH x 32 chunk buffer, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module wb_dma_buf
  import wb_dma_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [$clog2(BUF_DEPTH)-1:0] wr_idx_i,
  input  logic [31:0]                  wr_data_i,
  input  logic [$clog2(BUF_DEPTH)-1:0] rd_idx_i,
  output logic [31:0]                  rd_data_o
);

  logic [31:0] mem_q [BUF_DEPTH];

  // Capture read data one word per acknowledged beat
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone B3 master copying len_i words from src to dst, a chunk of
// up to BUF_DEPTH words at a time (read chunk into buffer, then write it out).
// Optional feature macro WB_DMA_BURST_EN: incrementing bursts; when undefined,
// classic single cycles with cyc/stb dropped for one cycle after every ack.
module wb_dma_copy
  import wb_dma_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic [2:0]       wbm_cti_o,
  output logic [1:0]       wbm_bte_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  input  logic             wbm_rty_i
);

  localparam int unsigned IdxW   = $clog2(BUF_DEPTH);
  localparam int unsigned ChunkW = IdxW + 1;

  function automatic logic [ChunkW-1:0] chunk_of(input logic [LEN_W-1:0] words);
    if (words >= LEN_W'(BUF_DEPTH)) return ChunkW'(BUF_DEPTH);
    return words[ChunkW-1:0];
  endfunction

  logic [1:0]        state_q, state_d;
  logic              phase_wr_q, phase_wr_d;  // phase to enter after the gap
  logic [31:0]       src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ChunkW-1:0] chunk_q, chunk_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0]       adr_q, adr_d, dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
  logic [2:0]        cti_q, cti_d;

  logic        ack_v, err_v, last_beat, in_beat, buf_we;
  logic [31:0] buf_rdata;

  // Responses only count while we strobe; retry is simply "no ack"
  assign ack_v     = stb_q & wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
  assign err_v     = stb_q & wbm_err_i;
  assign last_beat = (ChunkW'(idx_q) == chunk_q - 1'b1);

  wb_dma_buf #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk_i    (wb_clk_i),
    .we_i     (buf_we),
    .wr_idx_i (idx_q),
    .wr_data_i(wbm_dat_i),
    .rd_idx_i (idx_d),
    .rd_data_o(buf_rdata)
  );

  // FSM, address counters, remaining-length and beat index
  always_comb begin
    state_d    = state_q;
    phase_wr_d = phase_wr_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    chunk_d    = chunk_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    err_d      = err_q;
    buf_we     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d = 1'b0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            src_d   = src_adr_i & 32'hFFFF_FFFC;
            dst_d   = dst_adr_i & 32'hFFFF_FFFC;
            rem_d   = len_i;
            chunk_d = chunk_of(len_i);
            idx_d   = '0;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (err_v) begin
          state_d = StIdle;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else if (ack_v) begin
          buf_we = 1'b1;
          src_d  = src_q + 32'd4;
          if (last_beat) begin
            idx_d      = '0;
            phase_wr_d = 1'b1;
            state_d    = StGap;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StGap: begin
        state_d = phase_wr_q ? StWrite : StRead;
      end
      StWrite: begin
        if (err_v) begin
          state_d = StIdle;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else if (ack_v) begin
          dst_d = dst_q + 32'd4;
          if (last_beat) begin
            idx_d = '0;
            rem_d = rem_q - LEN_W'(chunk_q);
            if (rem_d == '0) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              chunk_d    = chunk_of(rem_d);
              phase_wr_d = 1'b0;
              state_d    = StGap;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are derived from the next state so every output is a flop
  always_comb begin
    in_beat = (state_d == StRead) || (state_d == StWrite);
`ifdef WB_DMA_BURST_EN
    stb_d = in_beat;
    cti_d = CTI_CLASSIC;
    if (in_beat) cti_d = (ChunkW'(idx_d) == chunk_d - 1'b1) ? CTI_EOB : CTI_INC;
`else
    // Classic mode idles the bus for one cycle after every acknowledged beat
    stb_d = in_beat & ~ack_v;
    cti_d = CTI_CLASSIC;
`endif
    cyc_d  = stb_d;
    busy_d = (state_d != StIdle);
    we_d   = stb_d & (state_d == StWrite);
    sel_d  = stb_d ? 4'hF : 4'h0;
    adr_d  = adr_q;
    dat_d  = dat_q;
    if (stb_d) adr_d = (state_d == StWrite) ? dst_d : src_d;
    if (we_d) dat_d = buf_rdata;
  end

  // State and output registers, synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      phase_wr_q <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      cti_q      <= CTI_CLASSIC;
    end else begin
      state_q    <= state_d;
      phase_wr_q <= phase_wr_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      chunk_q    <= chunk_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      cti_q      <= cti_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cti_o = cti_q;
  assign wbm_bte_o = BTE_LINEAR;

endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: randomized bench for wb_dma_copy with a memory slave model and a
// chunk-level reference model of the expected bus trace and final memory.
module tb_wb_dma_copy;
  import wb_dma_pkg::*;

  localparam int unsigned BUF_DEPTH = 8;
  localparam int unsigned LEN_W     = 16;
  localparam int          Depth     = BUF_DEPTH;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src_adr = '0, dst_adr = '0;
  logic [LEN_W-1:0] len_in = '0;
  logic             busy, done, err_flag;
  logic [31:0]      wb_adr, wb_dat_o;
  logic [3:0]       wb_sel;
  logic             wb_we, wb_cyc, wb_stb;
  logic [2:0]       wb_cti;
  logic [1:0]       wb_bte;
  logic [31:0]      wb_dat_i = '0;
  logic             wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;

  always #5 clk = ~clk;

  wb_dma_copy #(
    .BUF_DEPTH(BUF_DEPTH),
    .LEN_W    (LEN_W)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start_i  (start),
    .src_adr_i(src_adr),
    .dst_adr_i(dst_adr),
    .len_i    (len_in),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err_flag),
    .wbm_adr_o(wb_adr),
    .wbm_dat_o(wb_dat_o),
    .wbm_sel_o(wb_sel),
    .wbm_we_o (wb_we),
    .wbm_cyc_o(wb_cyc),
    .wbm_stb_o(wb_stb),
    .wbm_cti_o(wb_cti),
    .wbm_bte_o(wb_bte),
    .wbm_dat_i(wb_dat_i),
    .wbm_ack_i(wb_ack),
    .wbm_err_i(wb_err),
    .wbm_rty_i(wb_rty)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  logic [31:0] mem     [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];
  beat_t       exp_q[$];
  beat_t       obs_q[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ~a;
  endfunction

  function automatic logic [2:0] exp_cti(input bit last);
    logic [2:0] c;
    c = last ? CTI_EOB : CTI_INC;
`ifndef WB_DMA_BURST_EN
    c = CTI_CLASSIC;
`endif
    return c;
  endfunction

  bit          err_en = 0, err_we = 0, rty_en = 0, rty_we = 0, rty_pend = 0, wait_en = 0;
  logic [31:0] err_adr = '0, rty_adr = '0, rty_sv_adr = '0, rty_sv_dat = '0;
  int          cyc_n = 0, done_cnt = 0, done_cyc = 0, last_ack_cyc = 0, err_cyc = 0;
  int          gap_run = 0, gap_bad = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Memory slave plus protocol monitor, evaluated mid-cycle
  always @(negedge clk) begin : slave
    beat_t b;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_rty   = 1'b0;
    wb_dat_i = $urandom;
    if (rty_pend) begin
      check_eq("rty_stb", 32'(wb_stb), 32'd1);
      check_eq("rty_adr", wb_adr, rty_sv_adr);
      check_eq("rty_dat", wb_dat_o, rty_sv_dat);
      rty_pend = 0;
    end
    if (wb_cyc && wb_stb) begin
      if (err_en && wb_adr == err_adr && wb_we == err_we) begin
        wb_err  = 1'b1;
        err_en  = 0;
        err_cyc = cyc_n;
      end else if (rty_en && wb_adr == rty_adr && wb_we == rty_we) begin
        wb_rty     = 1'b1;
        rty_en     = 0;
        rty_pend   = 1;
        rty_sv_adr = wb_adr;
        rty_sv_dat = wb_dat_o;
      end else if (!(wait_en && $urandom_range(3, 0) == 0)) begin
        wb_ack = 1'b1;
        if (wb_we) mem[wb_adr] = wb_dat_o;
        else wb_dat_i = mem_rd(wb_adr);
        b.we  = wb_we;
        b.adr = wb_adr;
        b.dat = wb_we ? wb_dat_o : wb_dat_i;
        b.cti = wb_cti;
        obs_q.push_back(b);
        last_ack_cyc = cyc_n;
        check_eq("sel", 32'(wb_sel), 32'hF);
        check_eq("bte", 32'(wb_bte), 32'(BTE_LINEAR));
      end
    end else if ($urandom_range(3, 0) == 0) begin
      wb_ack = 1'b1;  // stray ack without strobe
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
      check_eq("done_cyc_low", 32'(wb_cyc), 32'd0);
      check_eq("done_busy_low", 32'(busy), 32'd0);
    end
    if (busy && !wb_cyc) gap_run++;
    else begin
      if (gap_run > 1) gap_bad++;
      gap_run = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    logic [31:0] a;
    a = base & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      mem[a] = $urandom;
      a += 32'd4;
    end
  endtask

  task automatic check_quiet(input string pfx);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_done"}, 32'(done), 32'd0);
    check_eq({pfx, "_err"}, 32'(err_flag), 32'd0);
    check_eq({pfx, "_cyc"}, 32'(wb_cyc), 32'd0);
    check_eq({pfx, "_stb"}, 32'(wb_stb), 32'd0);
    check_eq({pfx, "_we"}, 32'(wb_we), 32'd0);
    check_eq({pfx, "_adr"}, wb_adr, 32'd0);
    check_eq({pfx, "_dat"}, wb_dat_o, 32'd0);
    check_eq({pfx, "_sel"}, 32'(wb_sel), 32'd0);
    check_eq({pfx, "_cti"}, 32'(wb_cti), 32'd0);
    check_eq({pfx, "_bte"}, 32'(wb_bte), 32'd0);
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input bit waits, input bit poke,
                          input bit do_err, input logic [31:0] e_adr, input bit e_we,
                          input bit do_rty, input logic [31:0] r_adr);
    logic [31:0] s, d;
    logic [31:0] bufm [BUF_DEPTH];
    int          rem, c, start_cyc, nchunks, n;
    bit          aborted;
    beat_t       b;
    // Reference: chunked read-then-write, truncated at the erroring beat
    exp_q.delete();
    obs_q.delete();
    ref_mem = mem;
    s       = src & 32'hFFFF_FFFC;
    d       = dst & 32'hFFFF_FFFC;
    rem     = len;
    aborted = 0;
    while (rem > 0 && !aborted) begin
      c = (rem > Depth) ? Depth : rem;
      for (int i = 0; i < c; i++) begin
        if (do_err && !e_we && s == e_adr) begin
          aborted = 1;
          break;
        end
        bufm[i] = ref_rd(s);
        b.we = 1'b0; b.adr = s; b.dat = bufm[i]; b.cti = exp_cti(i == c - 1);
        exp_q.push_back(b);
        s += 32'd4;
      end
      if (!aborted) begin
        for (int i = 0; i < c; i++) begin
          if (do_err && e_we && d == e_adr) begin
            aborted = 1;
            break;
          end
          ref_mem[d] = bufm[i];
          b.we = 1'b1; b.adr = d; b.dat = bufm[i]; b.cti = exp_cti(i == c - 1);
          exp_q.push_back(b);
          d += 32'd4;
        end
      end
      rem -= c;
    end

    err_en = do_err; err_adr = e_adr; err_we = e_we;
    rty_en = do_rty; rty_adr = r_adr; rty_we = 1'b1;
    wait_en = waits; done_cnt = 0; gap_run = 0; gap_bad = 0;

    start     = 1'b1;
    src_adr   = src;
    dst_adr   = dst;
    len_in    = len[LEN_W-1:0];
    start_cyc = cyc_n;
    tick();
    start   = 1'b0;
    src_adr = $urandom;
    dst_adr = $urandom;
    len_in  = LEN_W'($urandom);
    if (len == 0) begin
      check_eq("zl_done", 32'(done), 32'd1);
      check_eq("zl_busy", 32'(busy), 32'd0);
      check_eq("zl_cyc", 32'(wb_cyc), 32'd0);
    end else begin
      check_eq("start_busy", 32'(busy), 32'd1);
      check_eq("start_cyc", 32'(wb_cyc), 32'd1);
      check_eq("start_stb", 32'(wb_stb), 32'd1);
      check_eq("start_err_clr", 32'(err_flag), 32'd0);
    end
    for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
      start = (poke && k == 2);  // start while busy must be ignored
      tick();
    end
    start = 1'b0;
    check_eq("done_seen", 32'(done_cnt), 32'd1);
    repeat (3) tick();
    check_eq("done_once", 32'(done_cnt), 32'd1);
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_cyc", 32'(wb_cyc), 32'd0);
    check_eq("end_err", 32'(err_flag), 32'(do_err));
    check_eq("gap_len", 32'(gap_bad), 32'd0);
    if (len == 0) check_eq("zl_latency", 32'(done_cyc), 32'(start_cyc + 1));
    else if (do_err) check_eq("abort_latency", 32'(done_cyc), 32'(err_cyc + 1));
    else check_eq("done_latency", 32'(done_cyc), 32'(last_ack_cyc + 1));
    if (!waits && !do_err && !do_rty && len > 0) begin
      nchunks = (len + Depth - 1) / Depth;
`ifdef WB_DMA_BURST_EN
      check_eq("xfer_cycles", 32'(done_cyc - start_cyc), 32'(2 * len + 2 * nchunks));
`else
      check_eq("xfer_cycles", 32'(done_cyc - start_cyc), 32'(4 * len + 0 * nchunks));
`endif
    end
    check_eq("beat_count", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq("beat_we", 32'(obs_q[i].we), 32'(exp_q[i].we));
      check_eq("beat_adr", obs_q[i].adr, exp_q[i].adr);
      check_eq("beat_dat", obs_q[i].dat, exp_q[i].dat);
      check_eq("beat_cti", 32'(obs_q[i].cti), 32'(exp_q[i].cti));
    end
    d = dst & 32'hFFFF_FFFC;
    for (int i = 0; i < len && i < 32; i++) begin
      check_eq("mem", mem_rd(d), ref_rd(d));
      d += 32'd4;
    end
  endtask

  initial begin : main
    logic [31:0] s, d;
    int          l;
    repeat (3) tick();
    check_quiet("rst");
    rst = 1'b0;
    tick();

    // Single chunk from the known table
    mem[32'h100] = 32'hA;
    mem[32'h104] = 32'hB;
    mem[32'h108] = 32'hC;
    run_xfer(32'h100, 32'h200, 3, 0, 0, 0, '0, 0, 0, '0);
    check_eq("tbl_200", mem_rd(32'h200), 32'hA);
    check_eq("tbl_208", mem_rd(32'h208), 32'hC);

    // Two chunks (8 + 2), full rate
    fill(32'h400, 10);
    run_xfer(32'h400, 32'h200, 10, 0, 0, 0, '0, 0, 0, '0);

    // Zero length
    run_xfer(32'h100, 32'h800, 0, 0, 0, 0, '0, 0, 0, '0);

    // Bus error on the second read beat
    run_xfer(32'h100, 32'h600, 3, 0, 0, 1, 32'h104, 0, 0, '0);

    // Retry on the first write beat; start also clears the sticky error
    run_xfer(32'h400, 32'h700, 5, 0, 0, 0, '0, 0, 1, 32'h700);

    // Reset during the write phase
    fill(32'h3000, 12);
    wait_en  = 0;
    done_cnt = 0;
    start    = 1'b1;
    src_adr  = 32'h3000;
    dst_adr  = 32'h4000;
    len_in   = 12;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && !(wb_we && wb_stb); k++) tick();
    check_eq("rst_reach_write", 32'(wb_we && wb_stb), 32'd1);
    rst      = 1'b1;
    done_cnt = 0;
    tick();
    check_quiet("midrst");
    rst = 1'b0;
    repeat (3) tick();
    check_eq("midrst_no_done", 32'(done_cnt), 32'd0);
    run_xfer(32'h3000, 32'h5000, 2, 0, 0, 0, '0, 0, 0, '0);

    // Address wrap-around on source and destination
    fill(32'hFFFF_FFF8, 5);
    run_xfer(32'hFFFF_FFF8, 32'h7000, 5, 0, 0, 0, '0, 0, 0, '0);
    fill(32'h7100, 6);
    run_xfer(32'h7100, 32'hFFFF_FFF4, 6, 1, 0, 0, '0, 0, 0, '0);

    // Randomized transfers with wait states, unaligned addresses, stray starts
    for (int it = 0; it < 10; it++) begin
      l = $urandom_range(20, 1);
      s = 32'h1000 + 32'(it) * 32'h100 + $urandom_range(3, 0);
      d = 32'h9000 + 32'(it) * 32'h100 + $urandom_range(3, 0);
      fill(s, l);
      run_xfer(s, d, l, it % 2 == 1, (l >= 4) && (it % 3 == 0), 0, '0, 0, 0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
